// File: rtl/sdram_bridge_pkg.sv
// Shared types and widths for the 32-bit word to 16-bit SDRAM bridge.
package sdram_bridge_pkg;

    localparam int unsigned SDRAM_ADDR_W = 23;
    localparam int unsigned SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StAccess,
        StResp
    } state_t;

endpackage

// File: rtl/sdram_word_bridge_if.sv
// Word-access handshake between the port manager (master) and the SDRAM bridge (slave).
interface sdram_word_bridge_if;

    logic        req;
    logic        we;
    logic [25:2] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, done, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, done, err, busy
    );

endinterface

// File: rtl/sdram_word_bridge.sv
// Splits one 32-bit word access into two 16-bit SDRAM transactions, low half first,
// assembles read data and holds done until the requester drops req.
module sdram_word_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_l,
    sdram_word_bridge_if.slave      host,
    output logic                    SDRAM_pll_locked,
    input  logic                    SDRAM_ready,
    output logic                    SDRAM_as,
    output logic                    SDRAM_rw,
    output logic [SDRAM_ADDR_W-1:0] SDRAM_addr,
    output logic [SDRAM_DATA_W-1:0] SDRAM_data_write,
    input  logic [SDRAM_DATA_W-1:0] SDRAM_data_read,
    input  logic                    SDRAM_done
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    state_t          state_q, state_d;
    logic            half_q, half_d;
    logic            we_q, we_d;
    logic [21:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            pll_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
            half_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            pll_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            pll_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (host.req) begin
                    we_d    = host.we;
                    // Bits 25:24 select the SDRAM region upstream and are dropped here.
                    addr_d  = host.addr[23:2];
                    wdata_d = host.wdata;
                    err_d   = 1'b0;
                    half_d  = 1'b0;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (SDRAM_ready) begin
                    cnt_d   = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (SDRAM_done) begin
                    if (!we_q) begin
                        if (half_q) rdata_d[31:16] = SDRAM_data_read;
                        else        rdata_d[15:0]  = SDRAM_data_read;
                    end
                    if (half_q) begin
                        state_d = StResp;
                    end else begin
                        half_d  = 1'b1;
                        state_d = StArm;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CntMax)) begin
                    // Abort: any remaining half is skipped, uncaptured rdata is kept.
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                if (!host.req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign SDRAM_as         = (state_q == StAccess);
    assign SDRAM_rw         = (state_q == StAccess) & we_q;
    assign SDRAM_addr       = {addr_q, half_q};
    assign SDRAM_data_write = half_q ? wdata_q[31:16] : wdata_q[15:0];
    assign SDRAM_pll_locked = pll_q;

    assign host.rdata = rdata_q;
    assign host.done  = (state_q == StResp);
    assign host.err   = err_q;
    assign host.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Directed bench for sdram_word_bridge with a behavioural SDRAM controller model.
module tb_sdram_word_bridge;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        sd_pll;
    logic        sd_ready = 1'b1;
    logic        sd_as;
    logic        sd_rw;
    logic [22:0] sd_addr;
    logic [15:0] sd_wdata;
    logic [15:0] sd_rdata = '0;
    logic        sd_done = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    // Controller model configuration (written by the stimulus only).
    int          l_cfg = 0;
    int          ready_delay = 0;
    bit          no_done = 1'b0;
    logic [15:0] rd_lo = '0;
    logic [15:0] rd_hi = '0;

    // Controller model state and cumulative logs (written by the model only).
    int          as_run = 0;
    int          arm_wait = 0;
    logic        prev_as = 1'b0;
    int          as_rises = 0;
    int          as_cycles = 0;
    int          wr_n = 0;
    logic [22:0] wr_addr [64];
    logic [15:0] wr_data [64];

    sdram_word_bridge_if host_if ();

    sdram_word_bridge #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .host             (host_if),
        .SDRAM_pll_locked (sd_pll),
        .SDRAM_ready      (sd_ready),
        .SDRAM_as         (sd_as),
        .SDRAM_rw         (sd_rw),
        .SDRAM_addr       (sd_addr),
        .SDRAM_data_write (sd_wdata),
        .SDRAM_data_read  (sd_rdata),
        .SDRAM_done       (sd_done)
    );

    always #5 clk = ~clk;

    // Controller: done after l_cfg+1 strobe cycles, ready held low ready_delay cycles per arm.
    always @(negedge clk) begin
        if (!rst_l) begin
            as_run   = 0;
            arm_wait = 0;
            sd_done  = 1'b0;
            sd_ready = 1'b1;
            prev_as  = 1'b0;
        end else begin
            sd_done = 1'b0;
            if (sd_as) begin
                if (!prev_as) as_rises++;
                as_cycles++;
                arm_wait = 0;
                sd_ready = 1'b1;
                if (!no_done && as_run == l_cfg) begin
                    sd_done  = 1'b1;
                    sd_rdata = sd_addr[0] ? rd_hi : rd_lo;
                    if (sd_rw) begin
                        wr_addr[wr_n % 64] = sd_addr;
                        wr_data[wr_n % 64] = sd_wdata;
                        wr_n++;
                    end
                end
                as_run++;
            end else begin
                as_run = 0;
                if (host_if.busy && arm_wait < ready_delay) begin
                    sd_ready = 1'b0;
                    arm_wait++;
                end else begin
                    sd_ready = 1'b1;
                end
                if (!host_if.busy) arm_wait = 0;
            end
            prev_as = sd_as;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Starts in the cycle req is first seen (cycle 0); returns the cycle done first rises.
    task automatic run_txn(input logic w, input logic [25:2] a, input logic [31:0] d,
                           input bit drop_mid, output int cyc);
        host_if.req   = 1'b1;
        host_if.we    = w;
        host_if.addr  = a;
        host_if.wdata = d;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk);
            #2;
            cyc++;
            if (drop_mid && sd_as && sd_addr[0]) host_if.req = 1'b0;
            if (host_if.done) break;
        end
        if (!host_if.done) check("done_wait", {31'd0, host_if.done}, 32'd1);
    endtask

    task automatic finish_txn(input string tag);
        host_if.req = 1'b0;
        @(posedge clk);
        #2;
        check({tag, "_done_low"}, {31'd0, host_if.done}, 32'd0);
        check({tag, "_idle"}, {31'd0, host_if.busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int base_wr;
        int base_rise;
        int base_cyc;
        host_if.req   = 1'b0;
        host_if.we    = 1'b0;
        host_if.addr  = '0;
        host_if.wdata = '0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_rdata", host_if.rdata, 32'd0);
        check("rst_done", {31'd0, host_if.done}, 32'd0);
        check("rst_err", {31'd0, host_if.err}, 32'd0);
        check("rst_busy", {31'd0, host_if.busy}, 32'd0);
        check("rst_as", {31'd0, sd_as}, 32'd0);
        check("rst_rw", {31'd0, sd_rw}, 32'd0);
        check("rst_addr", {9'd0, sd_addr}, 32'd0);
        check("rst_wdata", {16'd0, sd_wdata}, 32'd0);
        check("rst_pll", {31'd0, sd_pll}, 32'd0);
        rst_l = 1'b1;
        @(posedge clk);
        #2;
        check("pll_locked", {31'd0, sd_pll}, 32'd1);

        // Write, L=0: two halves to 0x20/0x21, done in cycle 5.
        base_wr = wr_n;
        run_txn(1'b1, 24'h000010, 32'hCAFE_F00D, 1'b0, cyc);
        check("wr_done_cycle", cyc, 32'd5);
        check("wr_lo_addr", {9'd0, wr_addr[base_wr % 64]}, 32'h20);
        check("wr_lo_data", {16'd0, wr_data[base_wr % 64]}, 32'hF00D);
        check("wr_hi_addr", {9'd0, wr_addr[(base_wr + 1) % 64]}, 32'h21);
        check("wr_hi_data", {16'd0, wr_data[(base_wr + 1) % 64]}, 32'hCAFE);
        check("wr_rdata_kept", host_if.rdata, 32'd0);
        finish_txn("wr");

        // Read, L=3: done in cycle 11.
        l_cfg = 3; rd_lo = 16'h1234; rd_hi = 16'h5678;
        run_txn(1'b0, 24'h000010, 32'd0, 1'b0, cyc);
        check("rd_done_cycle", cyc, 32'd11);
        check("rd_data", host_if.rdata, 32'h5678_1234);
        check("rd_err", {31'd0, host_if.err}, 32'd0);
        finish_txn("rd");

        // Ready low 4 cycles per arm: 8 extra cycles, strobe drops between halves.
        l_cfg = 0; ready_delay = 4; rd_lo = 16'hAAAA; rd_hi = 16'h5555;
        base_rise = as_rises;
        run_txn(1'b0, 24'h000123, 32'd0, 1'b0, cyc);
        check("rdy_done_cycle", cyc, 32'd13);
        check("rdy_as_gap", as_rises - base_rise, 32'd2);
        check("rdy_data", host_if.rdata, 32'h5555_AAAA);
        finish_txn("rdy");
        ready_delay = 0;

        // req dropped during the high half: both halves finish, done lasts one cycle.
        l_cfg = 3; rd_lo = 16'h1111; rd_hi = 16'h2222;
        base_rise = as_rises;
        run_txn(1'b0, 24'h000040, 32'd0, 1'b1, cyc);
        check("drop_done_cycle", cyc, 32'd11);
        check("drop_halves", as_rises - base_rise, 32'd2);
        check("drop_data", host_if.rdata, 32'h2222_1111);
        @(posedge clk);
        #2;
        check("drop_done_1cyc", {31'd0, host_if.done}, 32'd0);
        check("drop_idle", {31'd0, host_if.busy}, 32'd0);

        // A write must not disturb rdata.
        l_cfg = 0;
        run_txn(1'b1, 24'h000003, 32'h0BAD_0BAD, 1'b0, cyc);
        check("wr2_rdata_kept", host_if.rdata, 32'h2222_1111);
        finish_txn("wr2");

        // Timeout: 8 strobe cycles without done, high half never issued.
        no_done = 1'b1;
        base_rise = as_rises;
        base_cyc = as_cycles;
        run_txn(1'b0, 24'h000050, 32'd0, 1'b0, cyc);
        check("to_done_cycle", cyc, 32'd10);
        check("to_err", {31'd0, host_if.err}, 32'd1);
        check("to_as_cycles", as_cycles - base_cyc, 32'd8);
        check("to_no_high_half", as_rises - base_rise, 32'd1);
        check("to_rdata_kept", host_if.rdata, 32'h2222_1111);
        finish_txn("to");
        no_done = 1'b0;

        // Next accepted request clears err.
        rd_lo = 16'h0F0F; rd_hi = 16'hF0F0;
        run_txn(1'b0, 24'h000060, 32'd0, 1'b0, cyc);
        check("clr_done_cycle", cyc, 32'd5);
        check("clr_err", {31'd0, host_if.err}, 32'd0);
        check("clr_data", host_if.rdata, 32'hF0F0_0F0F);
        finish_txn("clr");

        // done arriving in the cycle the count is reached wins over the timeout.
        l_cfg = 7; rd_lo = 16'h7777; rd_hi = 16'h8888;
        run_txn(1'b0, 24'h000070, 32'd0, 1'b0, cyc);
        check("race_done_cycle", cyc, 32'd19);
        check("race_err", {31'd0, host_if.err}, 32'd0);
        check("race_data", host_if.rdata, 32'h8888_7777);
        finish_txn("race");

        // Reset during ACCESS drops everything at once; a fresh read then works.
        l_cfg = 3;
        host_if.req  = 1'b1;
        host_if.we   = 1'b0;
        host_if.addr = 24'h000080;
        repeat (3) @(posedge clk);
        #2;
        check("mid_in_access", {31'd0, sd_as}, 32'd1);
        rst_l = 1'b0;
        #1;
        check("mid_rst_as", {31'd0, sd_as}, 32'd0);
        check("mid_rst_done", {31'd0, host_if.done}, 32'd0);
        check("mid_rst_busy", {31'd0, host_if.busy}, 32'd0);
        check("mid_rst_rdata", host_if.rdata, 32'd0);
        host_if.req = 1'b0;
        @(posedge clk);
        #2;
        rst_l = 1'b1;
        @(posedge clk);
        #2;
        l_cfg = 0; rd_lo = 16'hBEEF; rd_hi = 16'hDEAD;
        run_txn(1'b0, 24'h000090, 32'd0, 1'b0, cyc);
        check("post_rst_cycle", cyc, 32'd5);
        check("post_rst_data", host_if.rdata, 32'hDEAD_BEEF);
        finish_txn("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
